sbox_share_ctrl: RTL and testbench
==================================

# sbox_share_ctrl

Time-multiplexed controller that shares four byte-substitution (`sbox`) lanes between two requesters. The first requester is the AES round datapath, which sends full 128-bit SubBytes jobs. The second is the key-expansion unit, which sends 32-bit SubWord jobs. A 128-bit state is processed as four 32-bit beats, and key words are interleaved between beats under a configurable arbitration policy. The block sits between the round controller, the key scheduler and four `sbox` instances, trading area for latency.

## Interface
- `KEY_PRIO`, default 1: selects the conflict policy. 1 means a pending key word always wins. 0 means round-robin between key and state on conflict cycles.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  state job request.
- `st_ready`  out  1  high when the block can accept a state job (IDLE only).
- `st_data`  in  128  input state; byte i = `st_data[8i+7:8i]`.
- `st_out_valid`  out  1  substituted state available.
- `st_out_ready`  in  1  consumer accepts the result.
- `st_out_data`  out  128  substituted state, same byte order as the input.
- `kw_valid`  in  1  key-word request.
- `kw_ready`  out  1  equals `!kw_pend`.
- `kw_data`  in  32  input word.
- `kw_out_valid`  out  1  one-cycle pulse; result valid (no backpressure).
- `kw_out_data`  out  32  substituted word; held until the next key result.
- `stall_cnt`  out  16  state-stall statistics (see Configuration).

## Operation
- Four `sbox` instances are combinational. Each cycle, a lane mux feeds them either the key-word buffer or beat `cnt` of the state buffer (bytes 4·cnt..4·cnt+3).

State FSM:
- IDLE, BUSY, DONE.
- IDLE: `st_ready`=1. On `st_valid && st_ready`, capture `st_data` into the buffer, set `cnt`=0, and go to BUSY.
- BUSY: on a cycle granted to state, write the four sbox outputs into result lanes `cnt` and increment `cnt`. When the grant occurs at `cnt`=3, go to DONE and set `st_out_valid`=1. A non-granted cycle holds `cnt`.
- DONE: hold `st_out_data` and `st_out_valid`. On `st_out_ready`, clear `st_out_valid` and go to IDLE.

Key path:
- On `kw_valid && kw_ready`, capture `kw_data` and set `kw_pend`.
- On a cycle granted to key, register the sbox outputs into `kw_out_data`, pulse `kw_out_valid`, and clear `kw_pend`.
- `kw_ready` is low while `kw_pend` is set, including the grant cycle.

Arbitration (evaluated each cycle):
- Only `kw_pend`: key is granted, in any FSM state.
- Only BUSY: state is granted.
- Both (conflict), `KEY_PRIO`=1: key is granted.
- Both, `KEY_PRIO`=0: the requester not granted at the previous conflict wins. The `last_conflict` register resets to "state", so the key wins the first conflict.

Other rules:
- `st_data` and `kw_data` are sampled only at the handshake edge; later input changes have no effect.
- Reset mid-job: everything clears asynchronously and in-flight jobs are discarded, with no output pulse.

## Timing
Reset values:
- `st_ready`=1 and `kw_ready`=1.
- `st_out_valid`=0, `st_out_data`=0.
- `kw_out_valid`=0, `kw_out_data`=0.
- `stall_cnt`=0; FSM=IDLE; `cnt`=0; `kw_pend`=0.

Latencies:
- State job, no contention: accepted at edge E0, beats at E1–E4, `st_out_valid` high after E4. Each key grant during BUSY adds one cycle.
- Key word, no contention: accepted at edge K0, `kw_out_valid` high for the cycle after K1. Under `KEY_PRIO`=0 a key word waits at most one beat.
- Minimum state throughput is one block per 6 cycles: IDLE accept, 4 beats, DONE handshake. Minimum key throughput is one word per 2 cycles.
- `st_ready` and `kw_ready` are decoded from registers only, with no combinational path from the valid inputs.

## Configuration
- Macro `SBOX_SHARE_STATS_EN`.
- Defined: `stall_cnt` increments on each BUSY cycle not granted to state. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: `stall_cnt` is tied to 0 and the counter logic is absent.
- Functional outputs are identical in both builds.

## Test plan
1. All-zero state, no key traffic → `st_out_data`=128'h6363…63 (all bytes 63), `st_out_valid` rises 4 cycles after accept.
2. FIPS-197 round-1 bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 (byte0 first) → d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
3. `kw_data`=32'h09cf4f3c while idle → `kw_out_data`=32'h018a84eb with a one-cycle `kw_out_valid` pulse one cycle after the accept edge.
4. `KEY_PRIO`=1: a key word injected during beat 1 → state result delayed exactly 1 cycle, and `stall_cnt`=1 with `SBOX_SHARE_STATS_EN` defined. With `KEY_PRIO`=0, back-to-back key words during BUSY alternate grants with state beats.
5. Hold `st_out_ready`=0 for 10 cycles in DONE → `st_out_data` stable and `st_ready`=0; a key word is still serviced in that window.
6. Assert `rst_n`=0 mid-BUSY → all outputs return to their reset values immediately, and no `st_out_valid` follows release.

Source files
------------

// File: rtl/sbox_share_ctrl.sv
// Shares four AES S-box lanes between 128-bit state jobs (four 32-bit beats) and 32-bit key words.
// Optional stall statistics are built only when SBOX_SHARE_STATS_EN is defined.

module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254 (maps 0 to 0), followed by the affine transform.
   function automatic logic [7:0] subst(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign y = subst(a);
endmodule

module sbox_share_ctrl #(
   parameter int unsigned KEY_PRIO = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [127:0] st_data,
   output logic         st_out_valid,
   input  logic         st_out_ready,
   output logic [127:0] st_out_data,
   input  logic         kw_valid,
   output logic         kw_ready,
   input  logic [31:0]  kw_data,
   output logic         kw_out_valid,
   output logic [31:0]  kw_out_data,
   output logic [15:0]  stall_cnt
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} st_state_t;

   st_state_t    state, state_nxt;
   logic [1:0]   cnt;
   logic [127:0] st_buf, st_res;
   logic [31:0]  kw_buf, kw_res, lane_in, lane_out;
   logic         kw_pend, kw_pulse, last_key;
   logic         busy, kw_grant, st_grant;

   assign busy     = (state == BUSY);
   // last_key records who won the previous conflict; the other side wins the next one.
   assign kw_grant = kw_pend && (!busy || (KEY_PRIO != 0) || !last_key);
   assign st_grant = busy && !kw_grant;
   assign lane_in  = kw_grant ? kw_buf : st_buf[{cnt, 5'd0} +: 32];

   for (genvar g = 0; g < 4; g++) begin : g_lane
      sbox u_sbox (.a(lane_in[8*g +: 8]), .y(lane_out[8*g +: 8]));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (st_valid) state_nxt = BUSY;
         BUSY:    if (st_grant && cnt == 2'd3) state_nxt = DONE;
         DONE:    if (st_out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= 2'd0;
         st_buf   <= '0;
         st_res   <= '0;
         kw_buf   <= '0;
         kw_res   <= '0;
         kw_pend  <= 1'b0;
         kw_pulse <= 1'b0;
         last_key <= 1'b0;
      end else begin
         if (state == IDLE && st_valid) begin
            st_buf <= st_data;
            cnt    <= 2'd0;
         end else if (st_grant) begin
            st_res[{cnt, 5'd0} +: 32] <= lane_out;
            cnt <= cnt + 2'd1;
         end
         kw_pulse <= kw_grant;
         if (kw_grant) begin
            kw_res  <= lane_out;
            kw_pend <= 1'b0;
         end else if (kw_valid && !kw_pend) begin
            kw_buf  <= kw_data;
            kw_pend <= 1'b1;
         end
         if (kw_pend && busy) last_key <= kw_grant;
      end
   end

`ifdef SBOX_SHARE_STATS_EN
   logic [15:0] stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                stall_q <= 16'h0000;
      else if (busy && !st_grant && stall_q != 16'hFFFF) stall_q <= stall_q + 16'h0001;
   end
   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

   assign st_ready     = (state == IDLE);
   assign st_out_valid = (state == DONE);
   assign st_out_data  = st_res;
   assign kw_ready     = !kw_pend;
   assign kw_out_valid = kw_pulse;
   assign kw_out_data  = kw_res;
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: one instance with key priority, one with round-robin.
// Both instances share all inputs; each scenario starts from reset.

module tb_sbox_share_ctrl;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         st_valid = 1'b0;
   logic [127:0] st_data = '0;
   logic         st_out_ready = 1'b0;
   logic         kw_valid = 1'b0;
   logic [31:0]  kw_data = '0;

   logic         st_ready_p, st_out_valid_p, kw_ready_p, kw_out_valid_p;
   logic [127:0] st_out_data_p;
   logic [31:0]  kw_out_data_p;
   logic [15:0]  stall_cnt_p;
   logic         st_ready_r, st_out_valid_r, kw_ready_r, kw_out_valid_r;
   logic [127:0] st_out_data_r;
   logic [31:0]  kw_out_data_r;
   logic [15:0]  stall_cnt_r;

   int errors = 0;
   int checks = 0;

`ifdef SBOX_SHARE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [127:0] ALL63   = {16{8'h63}};
   localparam logic [127:0] FIPS_IN = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_SB = 128'h3052411ee55db4b8f198bfe0ae1127d4;

   always #5 clk = ~clk;

   sbox_share_ctrl #(.KEY_PRIO(1)) dut_p (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready_p), .st_data(st_data),
      .st_out_valid(st_out_valid_p), .st_out_ready(st_out_ready), .st_out_data(st_out_data_p),
      .kw_valid(kw_valid), .kw_ready(kw_ready_p), .kw_data(kw_data),
      .kw_out_valid(kw_out_valid_p), .kw_out_data(kw_out_data_p), .stall_cnt(stall_cnt_p)
   );

   sbox_share_ctrl #(.KEY_PRIO(0)) dut_r (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready_r), .st_data(st_data),
      .st_out_valid(st_out_valid_r), .st_out_ready(st_out_ready), .st_out_data(st_out_data_r),
      .kw_valid(kw_valid), .kw_ready(kw_ready_r), .kw_data(kw_data),
      .kw_out_valid(kw_out_valid_r), .kw_out_data(kw_out_data_r), .stall_cnt(stall_cnt_r)
   );

   task automatic do_reset();
      st_valid = 1'b0; st_data = '0; st_out_ready = 1'b0; kw_valid = 1'b0; kw_data = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({st_ready_p, kw_ready_p, st_out_valid_p, kw_out_valid_p} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_flags_p: got %b want 1100", {st_ready_p, kw_ready_p, st_out_valid_p, kw_out_valid_p});
      end
      checks++;
      if ({st_out_data_p, kw_out_data_p, stall_cnt_p} !== '0) begin
         errors++;
         $display("FAIL reset_data_p: st=%h kw=%h stall=%h want all zero", st_out_data_p, kw_out_data_p, stall_cnt_p);
      end
      checks++;
      if ({st_ready_r, kw_ready_r, st_out_valid_r, kw_out_valid_r} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_flags_r: got %b want 1100", {st_ready_r, kw_ready_r, st_out_valid_r, kw_out_valid_r});
      end
   endtask

   task automatic test_zero_state();
      int lat;
      do_reset();
      st_valid = 1'b1; st_data = '0;
      @(negedge clk);
      st_valid = 1'b0;
      checks++;
      if (st_ready_p !== 1'b0) begin
         errors++;
         $display("FAIL zero_busy_ready: got %b want 0", st_ready_p);
      end
      lat = 0;
      while (!st_out_valid_p && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL zero_latency: got %0d want 4", lat);
      end
      checks++;
      if (st_out_data_p !== ALL63) begin
         errors++;
         $display("FAIL zero_data: got %h want %h", st_out_data_p, ALL63);
      end
      st_out_ready = 1'b1;
      @(negedge clk);
      st_out_ready = 1'b0;
      checks++;
      if ({st_ready_p, st_out_valid_p} !== 2'b10) begin
         errors++;
         $display("FAIL zero_return_idle: got %b want 10", {st_ready_p, st_out_valid_p});
      end
   endtask

   task automatic test_fips();
      int lat;
      do_reset();
      st_valid = 1'b1; st_data = FIPS_IN;
      @(negedge clk);
      st_valid = 1'b0; st_data = {4{32'hdeadbeef}};
      lat = 0;
      while (!st_out_valid_p && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (st_out_data_p !== FIPS_SB || lat !== 4) begin
         errors++;
         $display("FAIL fips_data: got %h lat %0d want %h lat 4", st_out_data_p, lat, FIPS_SB);
      end
   endtask

   task automatic test_key_idle();
      do_reset();
      kw_valid = 1'b1; kw_data = 32'h09cf4f3c;
      @(negedge clk);
      kw_valid = 1'b0; kw_data = 32'hffffffff;
      checks++;
      if ({kw_ready_p, kw_out_valid_p} !== 2'b00) begin
         errors++;
         $display("FAIL key_pending: ready/valid got %b want 00", {kw_ready_p, kw_out_valid_p});
      end
      @(negedge clk);
      checks++;
      if (kw_out_valid_p !== 1'b1 || kw_out_data_p !== 32'h018a84eb || kw_ready_p !== 1'b1) begin
         errors++;
         $display("FAIL key_result: valid=%b data=%h ready=%b want 1 018a84eb 1", kw_out_valid_p, kw_out_data_p, kw_ready_p);
      end
      @(negedge clk);
      checks++;
      if (kw_out_valid_p !== 1'b0 || kw_out_data_p !== 32'h018a84eb) begin
         errors++;
         $display("FAIL key_pulse_end: valid=%b data=%h want 0 018a84eb", kw_out_valid_p, kw_out_data_p);
      end
   endtask

   task automatic test_key_prio();
      int lat;
      do_reset();
      st_valid = 1'b1; st_data = '0;
      @(negedge clk);
      st_valid = 1'b0; kw_valid = 1'b1; kw_data = 32'h01000000;
      @(negedge clk);
      kw_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (kw_out_valid_p !== 1'b1 || kw_out_data_p !== 32'h7c636363) begin
         errors++;
         $display("FAIL prio_key: valid=%b data=%h want 1 7c636363", kw_out_valid_p, kw_out_data_p);
      end
      lat = 2;
      while (!st_out_valid_p && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 5 || st_out_data_p !== ALL63) begin
         errors++;
         $display("FAIL prio_latency: lat=%0d data=%h want 5 %h", lat, st_out_data_p, ALL63);
      end
      checks++;
      if (stall_cnt_p !== (STATS ? 16'd1 : 16'd0)) begin
         errors++;
         $display("FAIL prio_stall: got %0d want %0d", stall_cnt_p, STATS ? 1 : 0);
      end
   endtask

   task automatic test_round_robin();
      logic [5:0] kv_p, kv_r, sv_p, sv_r;
      do_reset();
      st_valid = 1'b1; st_data = FIPS_IN;
      @(negedge clk);
      st_valid = 1'b0; st_data = '1; kw_valid = 1'b1; kw_data = 32'h00000000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         kv_p[k] = kw_out_valid_p; kv_r[k] = kw_out_valid_r;
         sv_p[k] = st_out_valid_p; sv_r[k] = st_out_valid_r;
         if (k == 1) kw_data = 32'h09cf4f3c;
         if (k == 2) kw_valid = 1'b0;
      end
      checks++;
      if (kv_r !== 6'b010010 || sv_r !== 6'b100000) begin
         errors++;
         $display("FAIL rr_grants: key=%b state=%b want 010010 100000", kv_r, sv_r);
      end
      checks++;
      if (kv_p !== 6'b001010 || sv_p !== 6'b100000) begin
         errors++;
         $display("FAIL prio_grants: key=%b state=%b want 001010 100000", kv_p, sv_p);
      end
      checks++;
      if (st_out_data_r !== FIPS_SB || kw_out_data_r !== 32'h018a84eb) begin
         errors++;
         $display("FAIL rr_data: st=%h kw=%h want %h 018a84eb", st_out_data_r, kw_out_data_r, FIPS_SB);
      end
      checks++;
      if (stall_cnt_r !== (STATS ? 16'd2 : 16'd0)) begin
         errors++;
         $display("FAIL rr_stall: got %0d want %0d", stall_cnt_r, STATS ? 2 : 0);
      end
   endtask

   task automatic test_done_hold();
      int lat;
      int pulses;
      do_reset();
      st_valid = 1'b1; st_data = '0;
      @(negedge clk);
      st_valid = 1'b0;
      lat = 0;
      while (!st_out_valid_p && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (st_out_valid_p !== 1'b1 || st_ready_p !== 1'b0 || st_out_data_p !== ALL63) begin
            errors++;
            $display("FAIL hold_cycle%0d: valid=%b ready=%b data=%h want 1 0 %h", i, st_out_valid_p, st_ready_p, st_out_data_p, ALL63);
         end
         if (i == 0) begin kw_valid = 1'b1; kw_data = 32'h09cf4f3c; end
         if (i == 1) kw_valid = 1'b0;
         @(negedge clk);
         if (kw_out_valid_p) pulses++;
      end
      checks++;
      if (pulses !== 1 || kw_out_data_p !== 32'h018a84eb) begin
         errors++;
         $display("FAIL hold_key: pulses=%0d data=%h want 1 018a84eb", pulses, kw_out_data_p);
      end
      st_out_ready = 1'b1;
      @(negedge clk);
      st_out_ready = 1'b0;
      checks++;
      if (st_ready_p !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: st_ready=%b want 1", st_ready_p);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_reset();
      st_valid = 1'b1; st_data = FIPS_IN;
      @(negedge clk);
      st_valid = 1'b0; kw_valid = 1'b1; kw_data = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      kw_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({st_ready_p, kw_ready_p, st_out_valid_p, kw_out_valid_p} !== 4'b1100 ||
          {st_out_data_p, kw_out_data_p, stall_cnt_p} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: flags=%b st=%h kw=%h stall=%h want 1100 and zeros",
                  {st_ready_p, kw_ready_p, st_out_valid_p, kw_out_valid_p}, st_out_data_p, kw_out_data_p, stall_cnt_p);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (st_out_valid_p || kw_out_valid_p || st_out_valid_r || kw_out_valid_r) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_output: saw valid=%b want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_zero_state();
      test_fips();
      test_key_idle();
      test_key_prio();
      test_round_robin();
      test_done_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
